note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Step sequencer that drives the synth voice: holds an 8-step note pattern and, at a programmable tempo, loads the oscillator period and produces the note gate.
- Sits between the SPI configuration block and the synth core.
- Its `osc_count` output replaces the static SPI value, and its `trig` output is ORed into the synth trigger path.
- Pattern memory is written through a simple synchronous write port fed from the SPI side.

Parameters:
- STEPS, 8, number of pattern entries (power of two); `SW = log2(STEPS)`.
- TICK_W, 16, width of the tempo and gate counters.

Ports:
- clk  in  1  system clock, 20.48 MHz
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = play pattern, 0 = stop
- tick_div  in  TICK_W  step period minus 1, in clk cycles; values 0 and 1 are both treated as 1
- gate_len  in  TICK_W  trig high time per active step, in cycles; 0 = every step is a rest
- last_step  in  SW  index of the final step before wrapping to 0
- wr_en  in  1  pattern write strobe
- wr_addr  in  SW  pattern entry to write
- wr_note  in  12  oscillator count for the entry
- wr_active  in  1  1 = note, 0 = rest
- osc_count  out  12  oscillator count for the current step
- trig  out  1  gate to the synth ADSR
- step_idx  out  SW  current step index
- step_strobe  out  1  one-cycle pulse in the first cycle of each step
- playing  out  1  high while in PLAY

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All pattern entries become note=0, active=0.
  - All outputs are 0; tick and gate counters are 0.
- Pattern write: when `wr_en` is high at a clock edge, entry `wr_addr` := {`wr_active`, `wr_note`}. Writes are accepted in every state.
  - A write to the step currently playing does not change `osc_count` or `trig` for that step. It takes effect on the next visit to that entry.
- FSM, two states:
  - IDLE → PLAY: `run` sampled 1 at edge N. Cycle N+1 is the first cycle of step 0: `step_idx`=0, `step_strobe`=1, `osc_count` = note[0].
  - PLAY → IDLE: `run` sampled 0. In the next cycle `trig`=0, `playing`=0, `step_idx`=0 and the counters are cleared. `osc_count` holds its last value.
  - Re-asserting `run` restarts from step 0.
- Step timing:
  - Step length L = max(`tick_div`,1)+1 cycles.
  - The tick counter runs 0..L-1.
  - On the wrap, the step index advances: `step_idx` == `last_step` → 0, otherwise +1.
  - `tick_div`, `gate_len` and `last_step` are sampled at each step start and held for that step.
- Register updates at each step start: `osc_count` := note[idx]; `step_strobe` pulses for one cycle.
- Gate:
  - If active[idx]=1 and `gate_len`≠0, `trig`=1 for G = min(`gate_len`, L-1) cycles starting in the step's first cycle. Otherwise `trig`=0 for the whole step.
  - The clamp guarantees at least one low cycle of `trig` before the next step, so consecutive notes always retrigger the ADSR.
- `last_step` changed to a value below the current index: the current step completes, then the sequence wraps to 0. No out-of-range step ever plays.
- `rst` asserted mid-step: immediate IDLE, pattern cleared, `trig` drops asynchronously.
- Simultaneous events:
  - `run` falling on a step-boundary cycle: stop wins; no new `step_strobe`.
  - `wr_en` on the same edge as a step start reading that entry: the old entry is used.

Optional Feature:
- Macro: SEQ_SWING_EN.
- When defined:
  - Adds input `swing` (TICK_W wide), sampled at each even-step start and held for the following step. S = min(`swing`, L-1).
  - Even-indexed steps last L+S cycles; odd-indexed steps last L-S cycles.
  - The gate clamp uses each step's own length: G = min(`gate_len`, step_len-1). An odd step of length 1 therefore never asserts `trig`.
  - If `last_step` is even, the final even step still uses L+S; the pairing restarts at step 0.
- When not defined: no `swing` port, and every step lasts L cycles.

Test Plan:
- Reset, then write entry 0=(0x123, active) and entry 1=(0x200, rest); `last_step`=1, `tick_div`=9, `gate_len`=4, `run`=1 → step 0 starts 1 cycle after `run`: `osc_count`=0x123, `trig` high 4 cycles. Step 1 starts 10 cycles later: `osc_count`=0x200, `trig` stays 0. Step 0 repeats after 20 cycles.
- `gate_len`=50, `tick_div`=9, all entries active → `trig` high 9 cycles and low 1 cycle per step; `step_strobe` every 10 cycles.
- `tick_div`=0, `last_step`=7 → step period 2 cycles; `step_idx` sequence 0..7,0; `trig` alternates 1/0 when `gate_len`≥1.
- Deassert `run` at step 3, cycle 2, then re-assert → next cycle `trig`=0, `step_idx`=0, `playing`=0. On restart, step 0 plays first.
- Write entry 2 while step 2 is playing with a new note → current `osc_count` unchanged; the next visit to step 2 outputs the new value. `rst` pulse mid-note → `trig`=0 immediately and all entries read back as rests.
- (SEQ_SWING_EN) `tick_div`=9, `swing`=3 → even steps last 13 cycles, odd steps 7. With `swing`=20, odd steps last 1 cycle and `trig` stays 0 on them.

Source files
------------

// File: rtl/note_seq_if.sv
// Bus bundle between the SPI-side configuration logic and note_sequencer.
// Defining SEQ_SWING_EN adds the swing amount signal.
interface note_seq_if #(
  parameter int STEPS  = 8,
  parameter int TICK_W = 16
);
  localparam int SW = $clog2(STEPS);

`ifdef SEQ_SWING_EN
  logic [TICK_W-1:0] swing;
`endif
  logic              run;
  logic [TICK_W-1:0] tick_div;
  logic [TICK_W-1:0] gate_len;
  logic [SW-1:0]     last_step;
  logic              wr_en;
  logic [SW-1:0]     wr_addr;
  logic [11:0]       wr_note;
  logic              wr_active;
  logic [11:0]       osc_count;
  logic              trig;
  logic [SW-1:0]     step_idx;
  logic              step_strobe;
  logic              playing;

  modport master (
`ifdef SEQ_SWING_EN
    output swing,
`endif
    output run, tick_div, gate_len, last_step, wr_en, wr_addr, wr_note, wr_active,
    input  osc_count, trig, step_idx, step_strobe, playing
  );

  modport slave (
`ifdef SEQ_SWING_EN
    input  swing,
`endif
    input  run, tick_div, gate_len, last_step, wr_en, wr_addr, wr_note, wr_active,
    output osc_count, trig, step_idx, step_strobe, playing
  );
endinterface

// File: rtl/note_sequencer.sv
// Step sequencer: plays a STEPS-entry note pattern at a programmable tempo, driving
// the oscillator count and ADSR gate. Optional swing timing: define SEQ_SWING_EN.
module note_sequencer #(
  parameter int STEPS  = 8,
  parameter int TICK_W = 16
) (
  input  logic      clk,
  input  logic      rst,
  note_seq_if.slave bus
);
  localparam int SW = $clog2(STEPS);
  // One extra bit so a swung even step (up to twice the base length) still fits.
  localparam int LW = TICK_W + 1;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] tick_q, tick_d;
  logic [LW-1:0] lenM1_q, lenM1_d;
  logic [LW-1:0] gate_q, gate_d;
  logic [SW-1:0] step_q, step_d;
  logic [11:0]   osc_q, osc_d;
  logic          trig_q, trig_d;
  logic          strobe_q, strobe_d;
  logic [11:0]   note_q [STEPS];
  logic [STEPS-1:0] active_q;
`ifdef SEQ_SWING_EN
  logic [TICK_W-1:0] swing_q, swing_d;
  logic [LW-1:0]     swingRaw, swingClamp;
`endif

  logic          start;
  logic [SW-1:0] nextIdx;
  logic [LW-1:0] baseM1, stepM1, gateIn, tickInc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) note_q[i] <= '0;
      active_q <= '0;
    end else if (bus.wr_en) begin
      note_q[bus.wr_addr]   <= bus.wr_note;
      active_q[bus.wr_addr] <= bus.wr_active;
    end
  end

  // A step starts on leaving IDLE or on the tick wrap; a shrunk last_step forces a wrap.
  always_comb begin
    start   = 1'b0;
    nextIdx = '0;
    if (state_q == IDLE) begin
      start = bus.run;
    end else if (bus.run && (tick_q == lenM1_q)) begin
      start   = 1'b1;
      nextIdx = (step_q >= bus.last_step) ? '0 : step_q + 1'b1;
    end
  end

  always_comb begin
    baseM1 = (bus.tick_div < TICK_W'(2)) ? LW'(1) : LW'(bus.tick_div);
`ifdef SEQ_SWING_EN
    swingRaw   = nextIdx[0] ? LW'(swing_q) : LW'(bus.swing);
    swingClamp = (swingRaw < baseM1) ? swingRaw : baseM1;
    stepM1     = nextIdx[0] ? (baseM1 - swingClamp) : (baseM1 + swingClamp);
`else
    stepM1 = baseM1;
`endif
    // Clamping to length-1 leaves at least one low cycle so back-to-back notes retrigger.
    gateIn = (LW'(bus.gate_len) < stepM1) ? LW'(bus.gate_len) : stepM1;
    if (!active_q[nextIdx]) gateIn = '0;
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    step_d   = step_q;
    lenM1_d  = lenM1_q;
    gate_d   = gate_q;
    osc_d    = osc_q;
    trig_d   = 1'b0;
    strobe_d = 1'b0;
    tickInc  = tick_q + 1'b1;
`ifdef SEQ_SWING_EN
    swing_d  = swing_q;
`endif
    if (start) begin
      state_d  = PLAY;
      tick_d   = '0;
      step_d   = nextIdx;
      lenM1_d  = stepM1;
      gate_d   = gateIn;
      osc_d    = note_q[nextIdx];
      trig_d   = (gateIn != '0);
      strobe_d = 1'b1;
`ifdef SEQ_SWING_EN
      if (!nextIdx[0]) swing_d = bus.swing;
`endif
    end else if ((state_q == PLAY) && !bus.run) begin
      state_d = IDLE;
      tick_d  = '0;
      step_d  = '0;
      lenM1_d = '0;
      gate_d  = '0;
    end else if (state_q == PLAY) begin
      tick_d = tickInc;
      trig_d = (tickInc < gate_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      lenM1_q  <= '0;
      gate_q   <= '0;
      step_q   <= '0;
      osc_q    <= '0;
      trig_q   <= 1'b0;
      strobe_q <= 1'b0;
`ifdef SEQ_SWING_EN
      swing_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      lenM1_q  <= lenM1_d;
      gate_q   <= gate_d;
      step_q   <= step_d;
      osc_q    <= osc_d;
      trig_q   <= trig_d;
      strobe_q <= strobe_d;
`ifdef SEQ_SWING_EN
      swing_q  <= swing_d;
`endif
    end
  end

  assign bus.osc_count   = osc_q;
  assign bus.trig        = trig_q;
  assign bus.step_idx    = step_q;
  assign bus.step_strobe = strobe_q;
  assign bus.playing     = (state_q == PLAY);
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a step-level model predicts all outputs every cycle,
// and directed scenarios pin hand-computed values at key points.
module tb_note_sequencer;
  localparam int STEPS  = 8;
  localparam int TICK_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nCompared = 0;
  int   nMismatched = 0;
  bit   checkEn = 1'b0;

  note_seq_if #(.STEPS(STEPS), .TICK_W(TICK_W)) seqBus ();

  note_sequencer #(.STEPS(STEPS), .TICK_W(TICK_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(seqBus)
  );

  always #5 clk = ~clk;

  // Model state: position inside the current step and that step's length and gate.
  bit mPlay = 1'b0;
  int mIdx = 0, mPos = 0, mLen = 0, mG = 0, mOsc = 0, mSwing = 0;
  int patNote [STEPS];
  bit patAct  [STEPS];

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic modelStart(input int idx);
    int base;
    int len;
    int s;
    base = (seqBus.tick_div < 2) ? 1 : int'(seqBus.tick_div);
    len  = base + 1;
    s    = 0;
`ifdef SEQ_SWING_EN
    if (idx % 2 == 0) begin
      s      = minInt(int'(seqBus.swing), base);
      mSwing = int'(seqBus.swing);
      len    = len + s;
    end else begin
      s   = minInt(mSwing, base);
      len = len - s;
    end
`endif
    mPlay = 1'b1;
    mIdx  = idx;
    mPos  = 0;
    mLen  = len;
    mOsc  = patNote[idx];
    mG    = (patAct[idx] && seqBus.gate_len != 0) ? minInt(int'(seqBus.gate_len), len - 1) : 0;
  endtask

  initial begin
    for (int i = 0; i < STEPS; i++) begin
      patNote[i] = 0;
      patAct[i]  = 1'b0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mPlay = 1'b0; mIdx = 0; mPos = 0; mLen = 0; mG = 0; mOsc = 0; mSwing = 0;
        for (int i = 0; i < STEPS; i++) begin
          patNote[i] = 0;
          patAct[i]  = 1'b0;
        end
      end else begin
        if (!mPlay) begin
          if (seqBus.run) modelStart(0);
        end else if (!seqBus.run) begin
          mPlay = 1'b0; mIdx = 0; mPos = 0;
        end else if (mPos + 1 >= mLen) begin
          modelStart((mIdx >= int'(seqBus.last_step)) ? 0 : mIdx + 1);
        end else begin
          mPos++;
        end
        if (seqBus.wr_en) begin
          patNote[seqBus.wr_addr] = int'(seqBus.wr_note);
          patAct[seqBus.wr_addr]  = seqBus.wr_active;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("cyc_osc_count", seqBus.osc_count, mOsc);
        checkOutput("cyc_trig", seqBus.trig, (mPlay && mPos < mG) ? 1 : 0);
        checkOutput("cyc_step_idx", seqBus.step_idx, mIdx);
        checkOutput("cyc_step_strobe", seqBus.step_strobe, (mPlay && mPos == 0) ? 1 : 0);
        checkOutput("cyc_playing", seqBus.playing, mPlay ? 1 : 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic applyStimulus(input int addr, input int note, input bit act);
    seqBus.wr_en     = 1'b1;
    seqBus.wr_addr   = 3'(addr);
    seqBus.wr_note   = 12'(note);
    seqBus.wr_active = act;
    cyc();
    seqBus.wr_en     = 1'b0;
  endtask

  initial begin
    seqBus.run = 1'b0; seqBus.tick_div = '0; seqBus.gate_len = '0; seqBus.last_step = '0;
    seqBus.wr_en = 1'b0; seqBus.wr_addr = '0; seqBus.wr_note = '0; seqBus.wr_active = 1'b0;
`ifdef SEQ_SWING_EN
    seqBus.swing = '0;
`endif
    #2 rst = 1'b1;
    checkEn = 1'b1;
    cycles(2);
    rst = 1'b0;
    checkOutput("reset_playing", seqBus.playing, 0);
    checkOutput("reset_trig", seqBus.trig, 0);
    checkOutput("reset_osc", seqBus.osc_count, 0);
    checkOutput("reset_idx", seqBus.step_idx, 0);
    checkOutput("reset_strobe", seqBus.step_strobe, 0);

    // Note then rest, L=10, G=4
    applyStimulus(0, 'h123, 1'b1);
    applyStimulus(1, 'h200, 1'b0);
    seqBus.tick_div = 16'd9; seqBus.gate_len = 16'd4; seqBus.last_step = 3'd1;
    seqBus.run = 1'b1;
    cyc();
    checkOutput("t1_s0_osc", seqBus.osc_count, 'h123);
    checkOutput("t1_s0_strobe", seqBus.step_strobe, 1);
    checkOutput("t1_s0_trig", seqBus.trig, 1);
    checkOutput("t1_s0_playing", seqBus.playing, 1);
    cycles(3);
    checkOutput("t1_trig_4th", seqBus.trig, 1);
    cyc();
    checkOutput("t1_trig_5th", seqBus.trig, 0);
    cycles(6);
    checkOutput("t1_s1_idx", seqBus.step_idx, 1);
    checkOutput("t1_s1_osc", seqBus.osc_count, 'h200);
    checkOutput("t1_s1_strobe", seqBus.step_strobe, 1);
    checkOutput("t1_s1_trig", seqBus.trig, 0);
    cycles(10);
    checkOutput("t1_wrap_idx", seqBus.step_idx, 0);
    checkOutput("t1_wrap_osc", seqBus.osc_count, 'h123);

    // Gate clamp: gate_len 50 on L=10 gives 9 high, 1 low
    seqBus.run = 1'b0;
    cyc();
    checkOutput("t2_stopped", seqBus.playing, 0);
    for (int i = 0; i < STEPS; i++) applyStimulus(i, 'h100 + i * 'h11, 1'b1);
    seqBus.gate_len = 16'd50; seqBus.last_step = 3'd7;
    seqBus.run = 1'b1;
    cyc();
    checkOutput("t2_trig_on", seqBus.trig, 1);
    cycles(8);
    checkOutput("t2_trig_pos8", seqBus.trig, 1);
    cyc();
    checkOutput("t2_trig_pos9", seqBus.trig, 0);
    cyc();
    checkOutput("t2_s1_strobe", seqBus.step_strobe, 1);
    checkOutput("t2_s1_osc", seqBus.osc_count, 'h111);

    // Stop at step 3 cycle 2, then restart
    cycles(22);
    checkOutput("t4_s3_idx", seqBus.step_idx, 3);
    seqBus.run = 1'b0;
    cyc();
    checkOutput("t4_stop_trig", seqBus.trig, 0);
    checkOutput("t4_stop_idx", seqBus.step_idx, 0);
    checkOutput("t4_stop_playing", seqBus.playing, 0);
    checkOutput("t4_stop_osc_hold", seqBus.osc_count, 'h133);
    seqBus.run = 1'b1;
    cyc();
    checkOutput("t4_restart_idx", seqBus.step_idx, 0);
    checkOutput("t4_restart_osc", seqBus.osc_count, 'h100);

    // Fastest tempo: 2-cycle steps
    seqBus.run = 1'b0;
    cyc();
    seqBus.tick_div = 16'd0; seqBus.gate_len = 16'd3;
    seqBus.run = 1'b1;
    cyc();
    checkOutput("t3_trig_hi", seqBus.trig, 1);
    cyc();
    checkOutput("t3_trig_lo", seqBus.trig, 0);
    cyc();
    checkOutput("t3_s1_idx", seqBus.step_idx, 1);
    cycles(14);
    checkOutput("t3_wrap_idx", seqBus.step_idx, 0);
    checkOutput("t3_wrap_strobe", seqBus.step_strobe, 1);

    // Writes to the playing entry and on a step-start edge
    seqBus.run = 1'b0;
    cyc();
    seqBus.tick_div = 16'd9; seqBus.gate_len = 16'd50;
    seqBus.run = 1'b1;
    cyc();
    cycles(20);
    checkOutput("t5_s2_osc", seqBus.osc_count, 'h122);
    applyStimulus(2, 'h7AB, 1'b1);
    checkOutput("t5_hold_osc", seqBus.osc_count, 'h122);
    cycles(8);
    applyStimulus(3, 'h3CD, 1'b1);
    checkOutput("t5_same_edge_osc", seqBus.osc_count, 'h133);
    cycles(70);
    checkOutput("t5_new_idx", seqBus.step_idx, 2);
    checkOutput("t5_new_osc", seqBus.osc_count, 'h7AB);
    cyc();
    checkOutput("t5_trig_pre_rst", seqBus.trig, 1);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_trig", seqBus.trig, 0);
    checkOutput("t5_rst_playing", seqBus.playing, 0);
    cyc();
    rst = 1'b0;
    cyc();
    checkOutput("t5_rest_osc", seqBus.osc_count, 0);
    checkOutput("t5_rest_trig", seqBus.trig, 0);
    cycles(80);

    // Stop on the boundary cycle: no new strobe
    cycles(9);
    seqBus.run = 1'b0;
    cyc();
    checkOutput("t6_no_strobe", seqBus.step_strobe, 0);
    checkOutput("t6_idle", seqBus.playing, 0);

`ifdef SEQ_SWING_EN
    for (int i = 0; i < 4; i++) applyStimulus(i, 'h40 + i, 1'b1);
    seqBus.last_step = 3'd3; seqBus.tick_div = 16'd9; seqBus.swing = 16'd3;
    seqBus.run = 1'b1;
    cyc();
    cycles(13);
    checkOutput("sw_s1_idx", seqBus.step_idx, 1);
    checkOutput("sw_s1_strobe", seqBus.step_strobe, 1);
    cycles(7);
    checkOutput("sw_s2_idx", seqBus.step_idx, 2);
    seqBus.swing = 16'd20;
    cycles(20);
    checkOutput("sw_s0_idx", seqBus.step_idx, 0);
    cycles(19);
    checkOutput("sw_short_idx", seqBus.step_idx, 1);
    checkOutput("sw_short_trig", seqBus.trig, 0);
    cyc();
    checkOutput("sw_after_short_idx", seqBus.step_idx, 2);
    seqBus.run = 1'b0;
    cyc();
`endif

    cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
